// File: rtl/fifo_burst_reader.sv
// Burst reader: pulls BURST_WORDS words from a non-showahead FIFO and
// serialises each word onto a byte link, lane 0 (bits 7:0) first.
module fifo_burst_reader #(
  parameter int DATA_W      = 16,
  parameter int USEDW_W     = 10,
  parameter int BURST_WORDS = 512,
  parameter int PAUSE_EN    = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [USEDW_W-1:0] fifo_usedw,
  input  logic               fifo_full,
  input  logic [DATA_W-1:0]  fifo_q,
  output logic               fifo_rdreq,
  input  logic               next_rx_rdy,
  output logic               this_rx_rdy,
  output logic [7:0]         byte_out,
  output logic               byte_valid,
  output logic               burst_active,
  output logic               burst_done
);
  localparam int LANES    = DATA_W / 8;
  localparam int PH_W     = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int LEFT_W   = $clog2(LANES + 1);
  localparam int WCNT_W   = $clog2(BURST_WORDS + 1);
  localparam int LVL_W    = USEDW_W + 1;
  localparam logic [PH_W-1:0]   LAST_PH   = PH_W'(LANES - 1);
  localparam logic [LEFT_W-1:0] LANES_CNT = LEFT_W'(LANES);
  localparam logic [WCNT_W-1:0] BURST_CNT = WCNT_W'(BURST_WORDS);
  // One extra bit so a burst of exactly 2^USEDW_W words is only met by fifo_full.
  localparam logic [LVL_W-1:0]  BURST_LVL = LVL_W'(BURST_WORDS);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [PH_W-1:0]   phase_q, phase_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic              rdreq_q, rdreq_d;
  logic              done_q, done_d;
  logic              vld_p1_q;
  logic [LEFT_W-1:0] left_q;
  logic [DATA_W-1:0] word_p2_q;
  logic              kbyte_rdy;

  assign kbyte_rdy   = ({1'b0, fifo_usedw} >= BURST_LVL) || fifo_full;
  assign this_rx_rdy = ({1'b0, fifo_usedw} <  BURST_LVL) && !fifo_full;

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    wcnt_d  = wcnt_q;
    rdreq_d = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        // done_q blocks a back-to-back restart so IDLE lasts at least one cycle.
        if (kbyte_rdy && next_rx_rdy && !done_q) begin
          state_d = S_READ;
          phase_d = '0;
          rdreq_d = 1'b1;
          wcnt_d  = WCNT_W'(1);
        end
      end
      S_READ: begin
        if (phase_q == LAST_PH) begin
          if (wcnt_q == BURST_CNT) begin
            state_d = S_DRAIN;
          end else if ((PAUSE_EN != 0) && !next_rx_rdy) begin
            state_d = S_PAUSE;
          end else begin
            phase_d = '0;
            rdreq_d = 1'b1;
            wcnt_d  = wcnt_q + WCNT_W'(1);
          end
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end
      S_PAUSE: begin
        if (next_rx_rdy) begin
          state_d = S_READ;
          phase_d = '0;
          rdreq_d = 1'b1;
          wcnt_d  = wcnt_q + WCNT_W'(1);
        end
      end
      S_DRAIN: begin
        if (!rdreq_q && !vld_p1_q && (left_q <= LEFT_W'(1))) begin
          state_d = S_IDLE;
          wcnt_d  = '0;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Stage p0 -> p1: read strobe issued, FIFO data arrives next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      phase_q  <= '0;
      wcnt_q   <= '0;
      rdreq_q  <= 1'b0;
      done_q   <= 1'b0;
      vld_p1_q <= 1'b0;
      left_q   <= '0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      wcnt_q   <= wcnt_d;
      rdreq_q  <= rdreq_d;
      done_q   <= done_d;
      vld_p1_q <= rdreq_q;
      if (vld_p1_q) begin
        left_q <= LANES_CNT;
      end else if (left_q != '0) begin
        left_q <= left_q - LEFT_W'(1);
      end
    end
  end

  // Stage p1 -> p2: word captured, then shifted down one byte per cycle.
  always_ff @(posedge clk) begin
    if (vld_p1_q) begin
      word_p2_q <= fifo_q;
    end else begin
      word_p2_q <= word_p2_q >> 8;
    end
  end

  assign fifo_rdreq   = rdreq_q;
  assign byte_valid   = (left_q != '0);
  assign byte_out     = byte_valid ? word_p2_q[7:0] : 8'h00;
  assign burst_active = (state_q != S_IDLE);
  assign burst_done   = done_q;

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed bench for fifo_burst_reader: default, no-pause and 32-bit/4-word
// instances share one FIFO model and one event monitor selected by sel.
module tb_fifo_burst_reader;
  logic clk = 1'b0;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst;
  logic [9:0]  usedw_a, usedw_n, usedw_w;
  logic        full_a, full_n, full_w, rdy_a, rdy_n, rdy_w;
  logic [15:0] q_a, q_n;
  logic [31:0] q_w;
  logic        rd_a, rd_n, rd_w, trdy_a, trdy_n, trdy_w;
  logic        bv_a, bv_n, bv_w, act_a, act_n, act_w, done_a, done_n, done_w;
  logic [7:0]  bo_a, bo_n, bo_w;

  fifo_burst_reader u_a (
    .clk(clk), .rst(rst), .fifo_usedw(usedw_a), .fifo_full(full_a), .fifo_q(q_a),
    .fifo_rdreq(rd_a), .next_rx_rdy(rdy_a), .this_rx_rdy(trdy_a), .byte_out(bo_a),
    .byte_valid(bv_a), .burst_active(act_a), .burst_done(done_a));

  fifo_burst_reader #(.PAUSE_EN(0)) u_n (
    .clk(clk), .rst(rst), .fifo_usedw(usedw_n), .fifo_full(full_n), .fifo_q(q_n),
    .fifo_rdreq(rd_n), .next_rx_rdy(rdy_n), .this_rx_rdy(trdy_n), .byte_out(bo_n),
    .byte_valid(bv_n), .burst_active(act_n), .burst_done(done_n));

  fifo_burst_reader #(.DATA_W(32), .BURST_WORDS(4)) u_w (
    .clk(clk), .rst(rst), .fifo_usedw(usedw_w), .fifo_full(full_w), .fifo_q(q_w),
    .fifo_rdreq(rd_w), .next_rx_rdy(rdy_w), .this_rx_rdy(trdy_w), .byte_out(bo_w),
    .byte_valid(bv_w), .burst_active(act_w), .burst_done(done_w));

  int          sel = 0;
  logic        m_rd, m_bv, m_done, m_act, m_rdy;
  logic [7:0]  m_bo;
  int          rdc[$];
  logic [7:0]  by[$];
  int          byc[$];
  logic [31:0] wd[$];
  int          ndone = 0, done_c = 0, rlow = 0;
  logic        done_act = 1'b0;
  logic        rs = 1'b0;
  int          widx = 0, wbase = 0;
  int          bR = 0, bB = 0, bW = 0, bL = 0;
  int          checks = 0, failures = 0;
  logic [31:0] wtab [4] = '{32'h44332211, 32'h88776655, 32'hCCBBAA99, 32'h00FFEEDD};
  logic [31:0] mw;

  always_comb begin
    m_rd = rd_a; m_bv = bv_a; m_bo = bo_a; m_done = done_a; m_act = act_a; m_rdy = rdy_a;
    if (sel == 1) begin
      m_rd = rd_n; m_bv = bv_n; m_bo = bo_n; m_done = done_n; m_act = act_n; m_rdy = rdy_n;
    end else if (sel == 2) begin
      m_rd = rd_w; m_bv = bv_w; m_bo = bo_w; m_done = done_w; m_act = act_w; m_rdy = rdy_w;
    end
  end

  always @(negedge clk) begin
    rs = m_rd;
    if (m_rd) begin
      rdc.push_back(cyc);
      if (!m_rdy) rlow++;
    end
    if (m_bv) begin
      by.push_back(m_bo);
      byc.push_back(cyc);
    end
    if (m_done) begin
      ndone++;
      done_c   = cyc;
      done_act = m_act;
    end
  end

  // Non-showahead FIFO: data for a read strobe appears the following cycle.
  always @(posedge clk) begin
    if (rs) begin
      mw = (sel == 2) ? wtab[(widx - wbase) & 3] : 32'((widx - wbase) & 511);
      q_a <= mw[15:0];
      q_n <= mw[15:0];
      q_w <= mw;
      wd.push_back(mw);
      widx <= widx + 1;
    end
  end

  task automatic chk(input string t, input longint got, input longint exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", t, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic mark();
    bR = rdc.size(); bB = by.size(); bW = wd.size(); bL = rlow; wbase = widx;
  endtask

  task automatic wait_reads(input int n, input int lim);
    int k = 0;
    while ((rdc.size() - bR) < n && k < lim) begin
      step();
      k++;
    end
    chk("wait_reads", longint'((rdc.size() - bR) >= n), 1);
  endtask

  task automatic wait_done(input int lim);
    int b = ndone;
    int k = 0;
    while (ndone == b && k < lim) begin
      step();
      k++;
    end
    chk("wait_done", ndone - b, 1);
  endtask

  task automatic check_burst(input string t, input int nw, input int ln,
                             input int gaps, input int extra);
    int nr = rdc.size() - bR;
    int nb = by.size() - bB;
    int g = 0;
    int errs = 0;
    logic [7:0] e;
    chk({t, "_reads"}, nr, nw);
    chk({t, "_bytes"}, nb, nw * ln);
    if (nr == nw && nb == nw * ln && (wd.size() - bW) >= nw) begin
      for (int i = 1; i < nw; i++)
        if (rdc[bR+i] - rdc[bR+i-1] != ln) g++;
      for (int j = 0; j < nw * ln; j++) begin
        e = 8'(wd[bW + j / ln] >> (8 * (j % ln)));
        if (by[bB+j] !== e) errs++;
      end
      chk({t, "_read_gaps"}, g, gaps);
      chk({t, "_byte_order"}, errs, 0);
      chk({t, "_first_byte"}, byc[bB], rdc[bR] + 2);
      chk({t, "_byte_span"}, byc[bB + nb - 1] - byc[bB], nw * ln - 1 + extra);
      chk({t, "_done_cycle"}, done_c, rdc[bR] + nw * ln + 2 + extra);
      chk({t, "_active_at_done"}, done_act, 0);
    end
  endtask

  initial begin
    int c, d, drop, u, rc, nlow;
    rst = 1'b1;
    usedw_a = '0; usedw_n = '0; usedw_w = '0;
    full_a = 1'b0; full_n = 1'b0; full_w = 1'b0;
    rdy_a = 1'b0; rdy_n = 1'b0; rdy_w = 1'b0;
    repeat (2) @(posedge clk);
    step();
    chk("rst_out_a", {rd_a, bv_a, act_a, done_a, bo_a}, 0);
    chk("rst_out_n", {rd_n, bv_n, act_n, done_n, bo_n}, 0);
    chk("rst_out_w", {rd_w, bv_w, act_w, done_w, bo_w}, 0);
    chk("rst_thisrdy_a", trdy_a, 1);

    // 511 words buffered: no burst; fifo_full then triggers one.
    @(posedge clk); #1;
    rst = 1'b0; usedw_a = 10'd511; rdy_a = 1'b1;
    mark();
    repeat (4) step();
    chk("usedw511_no_read", rdc.size() - bR, 0);
    chk("usedw511_thisrdy", trdy_a, 1);
    chk("usedw511_idle", act_a, 0);
    @(posedge clk); #1;
    full_a = 1'b1; c = cyc;
    #1 chk("full_thisrdy", trdy_a, 0);
    wait_reads(1, 5);
    full_a = 1'b0; usedw_a = 10'd512;
    chk("b1_start", rdc[bR], c + 1);
    wait_done(1200);
    check_burst("b1", 512, 2, 0, 0);
    chk("b1_byte0", by[bB], 8'h00);
    chk("b1_byte1", by[bB+1], 8'h00);
    chk("b1_byte2", by[bB+2], 8'h01);
    chk("b1_byte1022", by[bB+1022], 8'hFF);
    chk("b1_byte1023", by[bB+1023], 8'h01);

    // Trigger still held: restart after one idle cycle, then pause after word 100.
    d = done_c;
    mark();
    wait_reads(100, 400);
    @(posedge clk); #1;
    rdy_a = 1'b0; drop = cyc;
    repeat (20) @(posedge clk);
    #1;
    rdy_a = 1'b1; usedw_a = '0; u = cyc;
    wait_done(1200);
    check_burst("b2", 512, 2, 1, 20);
    chk("b2_restart_gap", rdc[bR], d + 2);
    chk("b2_no_read_paused", rlow - bL, 0);
    nlow = 0;
    for (int j = bB; j < by.size(); j++)
      if (byc[j] >= drop && byc[j] < u) nlow++;
    chk("b2_bytes_paused_le3", longint'(nlow <= 3), 1);
    chk("b2_resume_word101", rdc[bR+100], u + 1);

    // Reset at word 50, then a fresh burst.
    step();
    mark();
    usedw_a = 10'd512;
    wait_reads(50, 200);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    step();
    chk("midrst_out", {rd_a, bv_a, act_a, done_a, bo_a}, 0);
    rc = cyc;
    mark();
    wait_reads(1, 5);
    usedw_a = '0;
    chk("midrst_restart", rdc[bR], rc + 1);
    wait_done(1200);
    check_burst("b3", 512, 2, 0, 0);

    // PAUSE_EN=0: the same drop of next_rx_rdy must not stall the burst.
    sel = 1;
    step();
    mark();
    usedw_n = 10'd512; rdy_n = 1'b1; c = cyc;
    wait_reads(100, 400);
    @(posedge clk); #1 rdy_n = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    rdy_n = 1'b1; usedw_n = '0;
    wait_done(1200);
    check_burst("np", 512, 2, 0, 0);
    chk("np_start", rdc[bR], c + 1);

    // 32-bit words, 4-word bursts.
    sel = 2;
    step();
    mark();
    usedw_w = 10'd4; rdy_w = 1'b1; c = cyc;
    #1 chk("w32_thisrdy", trdy_w, 0);
    wait_reads(1, 5);
    usedw_w = '0;
    chk("w32_start", rdc[bR], c + 1);
    wait_done(60);
    check_burst("w32", 4, 4, 0, 0);
    chk("w32_byte0", by[bB], 8'h11);
    chk("w32_byte1", by[bB+1], 8'h22);
    chk("w32_byte3", by[bB+3], 8'h44);
    chk("w32_byte15", by[bB+15], 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
